// File: rtl/piso_pkg.sv
// Shared definitions for the framed serial transmit controller:
// state encoding, line idle level and a counter-width helper.
package piso_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE = 1'b1;

  // Width of a counter spanning 0..n-1, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// WIDTH-bit right-shift register feeding the serial line.
// Ports: clk, rst (async active-low), ld (load in, wins over sh),
// sh (shift right, 0 fill), in (parallel word), q (bit 0).
module piso_shift
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             sh,
  input  logic [WIDTH-1:0] in,
  output logic             q
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else if (ld) begin
      sr_q <= in;
    end else if (sh) begin
      sr_q <= sr_q >> 1;
    end
  end

  assign q = sr_q[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Framed serial transmitter: start, WIDTH data bits LSB-first,
// optional even parity, stop. Each bit lasts CLKS_PER_BIT clocks.
// Ports: clk, rst (async active-low), in_data/in_valid/in_ready
// (producer handshake), ser_out (idle high), busy, done (1-cycle).
module piso_tx_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int DIV_W = cnt_w(CLKS_PER_BIT);
  localparam int CNT_W = cnt_w(WIDTH);

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             ser_q, ser_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic sr_ld;
  logic sr_sh;
  logic sr_bit;
  logic bit_end;

  piso_shift #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk(clk),
    .rst(rst),
    .ld (sr_ld),
    .sh (sr_sh),
    .in (in_data),
    .q  (sr_bit)
  );

  assign bit_end = (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      ser_q   <= LINE_IDLE;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      ser_q   <= ser_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // ser_out is registered, so each data bit is captured from
  // bit 0 on the edge that starts it, and the register shifts on
  // that same edge to stage the following bit in bit 0.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    ser_d   = ser_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sr_ld   = 1'b0;
    sr_sh   = 1'b0;

    if (state_q != ST_IDLE) begin
      div_d = bit_end ? '0 : DIV_W'(div_q + 1'b1);
    end

    case (state_q)
      ST_IDLE: begin
        ser_d  = LINE_IDLE;
        rdy_d  = 1'b1;
        busy_d = 1'b0;
        if (in_valid && rdy_q) begin
          sr_ld   = 1'b1;
          par_d   = ^in_data;
          state_d = ST_START;
          div_d   = '0;
          ser_d   = 1'b0;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          ser_d   = sr_bit;
          sr_sh   = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (cnt_q == CNT_LAST) begin
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              ser_d   = par_q;
            end else begin
              state_d = ST_STOP;
              ser_d   = LINE_IDLE;
            end
          end else begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
            ser_d = sr_bit;
            sr_sh = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          ser_d   = LINE_IDLE;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          ser_d   = LINE_IDLE;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ser_d   = LINE_IDLE;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign in_ready = rdy_q;
  assign ser_out  = ser_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: three configurations checked against a
// frame-level model every cycle, plus literal waveform checks.
module tb_piso_tx_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] din  [3];
  logic       vin  [3];
  logic       rdy  [3];
  logic       ser  [3];
  logic       bsy  [3];
  logic       dn   [3];

  int nchk;
  int nfail;

  piso_tx_ctrl #(
    .WIDTH(4), .CLKS_PER_BIT(4), .PARITY_EN(1)
  ) u_d0 (
    .clk(clk), .rst(rst),
    .in_data(din[0]), .in_valid(vin[0]),
    .in_ready(rdy[0]), .ser_out(ser[0]),
    .busy(bsy[0]), .done(dn[0])
  );

  piso_tx_ctrl #(
    .WIDTH(4), .CLKS_PER_BIT(4), .PARITY_EN(0)
  ) u_d1 (
    .clk(clk), .rst(rst),
    .in_data(din[1]), .in_valid(vin[1]),
    .in_ready(rdy[1]), .ser_out(ser[1]),
    .busy(bsy[1]), .done(dn[1])
  );

  piso_tx_ctrl #(
    .WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(1)
  ) u_d2 (
    .clk(clk), .rst(rst),
    .in_data(din[2]), .in_valid(vin[2]),
    .in_ready(rdy[2]), .ser_out(ser[2]),
    .busy(bsy[2]), .done(dn[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [7:0] got,
                     logic [7:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  function automatic int cpb(int g);
    return (g == 2) ? 1 : 4;
  endfunction

  function automatic int pen(int g);
    return (g == 1) ? 0 : 1;
  endfunction

  function automatic int flen(int g);
    return (2 + 4 + pen(g)) * cpb(g);
  endfunction

  int         mt [3];
  logic [3:0] mw [3];

  function automatic logic fbit(int g, int i);
    if (i == 0) return 1'b0;
    if (i <= 4) return mw[g][i-1];
    if (pen(g) != 0 && i == 5) return ^mw[g];
    return 1'b1;
  endfunction

  initial for (int g = 0; g < 3; g++) mt[g] = -1;

  // mt = cycles since accept; flen means the done cycle.
  always @(posedge clk or negedge rst) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst) begin
        mt[g] = -1;
      end else if ((mt[g] < 0 || mt[g] == flen(g))
                   && vin[g]) begin
        mt[g] = 0;
        mw[g] = din[g];
      end else if (mt[g] >= 0 && mt[g] < flen(g)) begin
        mt[g] = mt[g] + 1;
      end else begin
        mt[g] = -1;
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      logic es, er, eb, ed;
      if (mt[g] < 0) begin
        es = 1; er = 1; eb = 0; ed = 0;
      end else if (mt[g] == flen(g)) begin
        es = 1; er = 1; eb = 0; ed = 1;
      end else begin
        es = fbit(g, mt[g] / cpb(g));
        er = 0; eb = 1; ed = 0;
      end
      chk($sformatf("cyc%0t_d%0d_ser", $time, g),
          8'(ser[g]), 8'(es));
      chk($sformatf("cyc%0t_d%0d_rdy", $time, g),
          8'(rdy[g]), 8'(er));
      chk($sformatf("cyc%0t_d%0d_busy", $time, g),
          8'(bsy[g]), 8'(eb));
      chk($sformatf("cyc%0t_d%0d_done", $time, g),
          8'(dn[g]), 8'(ed));
    end
  end

  // ---------------- directed stimulus ----------------
  logic cs [64];
  logic cr [64];
  logic cd [64];

  task automatic send(int g, logic [3:0] w);
    @(negedge clk);
    din[g] = w;
    vin[g] = 1'b1;
    @(posedge clk);
    #1;
    vin[g] = 1'b0;
    din[g] = ~w;
  endtask

  task automatic cap(int g, int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cs[k] = ser[g];
      cr[k] = rdy[g];
      cd[k] = dn[g];
    end
  endtask

  function automatic logic [7:0] lv(int nb, int c, int off);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < nb; i++) r[i] = cs[i*c+off];
    return r;
  endfunction

  function automatic int ndone(int a, int b);
    int s;
    s = 0;
    for (int k = a; k < b; k++) s += int'(cd[k]);
    return s;
  endfunction

  function automatic int nrdy(int a, int b);
    int s;
    s = 0;
    for (int k = a; k < b; k++) s += int'(cr[k]);
    return s;
  endfunction

  initial begin
    int ridle;
    bit seen;
    nchk  = 0;
    nfail = 0;
    rst   = 1'b0;
    for (int g = 0; g < 3; g++) begin
      din[g] = 4'b0101;
      vin[g] = 1'b1;
    end

    // 1: reset with in_valid high
    repeat (3) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        chk("rst_ser", 8'(ser[g]), 8'd1);
        chk("rst_rdy", 8'(rdy[g]), 8'd1);
        chk("rst_busy", 8'(bsy[g]), 8'd0);
        chk("rst_done", 8'(dn[g]), 8'd0);
      end
    end
    for (int g = 0; g < 3; g++) vin[g] = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 2: default frame of 0111
    send(0, 4'b0111);
    cap(0, 29);
    chk("t2_lvl_head", lv(7, 4, 0), 8'b1101110);
    chk("t2_lvl_tail", lv(7, 4, 3), 8'b1101110);
    chk("t2_done28", 8'(cd[28]), 8'd1);
    chk("t2_done_early", 8'(ndone(0, 28)), 8'd0);
    chk("t2_rdy_low", 8'(nrdy(0, 28)), 8'd0);
    repeat (2) @(negedge clk);

    // 3: no parity, 1010
    send(1, 4'b1010);
    cap(1, 25);
    chk("t3_lvl_head", lv(6, 4, 0), 8'b110100);
    chk("t3_lvl_tail", lv(6, 4, 3), 8'b110100);
    chk("t3_done24", 8'(cd[24]), 8'd1);
    chk("t3_done_early", 8'(ndone(0, 24)), 8'd0);
    repeat (2) @(negedge clk);

    // 6: one clock per bit, 1000
    send(2, 4'b1000);
    cap(2, 8);
    chk("t6_lvl", lv(7, 1, 0), 8'b1110000);
    chk("t6_done7", 8'(cd[7]), 8'd1);
    chk("t6_done_early", 8'(ndone(0, 7)), 8'd0);
    repeat (2) @(negedge clk);

    // 4: back-to-back 0001 then 1111
    @(negedge clk);
    din[0] = 4'b0001;
    vin[0] = 1'b1;
    @(posedge clk);
    #1 din[0] = 4'b1111;
    ridle = 0;
    seen  = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      ridle += int'(rdy[0]);
      if (dn[0]) begin
        seen = 1'b1;
        chk("t4_done_ser", 8'(ser[0]), 8'd1);
      end
    end
    chk("t4_done_seen", 8'(seen), 8'd1);
    @(posedge clk);
    #1 vin[0] = 1'b0;
    cap(0, 29);
    chk("t4_idle_cycles", 8'(ridle), 8'd1);
    chk("t4_second_start", 8'(cs[0]), 8'd0);
    chk("t4_second_rdy", 8'(cr[0]), 8'd0);
    chk("t4_lvl", lv(7, 4, 0), 8'b1011110);
    chk("t4_parity0", 8'(cs[20]), 8'd0);
    chk("t4_done28", 8'(cd[28]), 8'd1);
    repeat (2) @(negedge clk);

    // 5: reset during data bit 2 of 0111
    send(0, 4'b0111);
    cap(0, 14);
    chk("t5_pre_busy", 8'(bsy[0]), 8'd1);
    #1 rst = 1'b0;
    #1;
    chk("t5_async_ser", 8'(ser[0]), 8'd1);
    chk("t5_async_rdy", 8'(rdy[0]), 8'd1);
    chk("t5_async_busy", 8'(bsy[0]), 8'd0);
    chk("t5_async_done", 8'(dn[0]), 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cap(0, 30);
    chk("t5_no_done", 8'(ndone(0, 30)), 8'd0);
    send(0, 4'b0010);
    cap(0, 29);
    chk("t5_new_lvl", lv(7, 4, 0), 8'b1100100);
    chk("t5_new_done", 8'(cd[28]), 8'd1);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
